// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction memory responder.
// Pipe entries carry the word index at a fixed width; the top keeps only the bits its depth needs.
package instr_mem_pkg;

  localparam int unsigned LATENCY_MIN     = 1;
  localparam int unsigned LATENCY_MAX     = 4;
  localparam int unsigned OUTSTANDING_MIN = 1;
  localparam int unsigned OUTSTANDING_MAX = 4;

  localparam int unsigned IDX_W = 30;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             err;
  } pipe_entry_t;

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr,
                                                  input logic [31:0] base);
    logic [31:0] offset;
    offset = addr - base;
    return offset[31:2];
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH_WORDS x 32 storage, one synchronous read port and one write port.
// Read data registers on re and holds otherwise; a same-word write in the read cycle returns old data.
module instr_mem_array #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [31:0]                    rdata,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [31:0]                    wdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-side req/gnt/rvalid memory responder: in-order responses LATENCY cycles after grant, no rvalid backpressure.
// Range checking with err responses is built when INSTR_MEM_ERR_CHECK_EN is defined; otherwise addresses wrap.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned NUM_OUTSTANDING = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           instr_req_i,
  output logic                           instr_gnt_o,
  input  logic [31:0]                    instr_addr_i,
  output logic [31:0]                    instr_rdata_o,
  output logic                           instr_rvalid_o,
  output logic                           instr_err_o,
  input  logic                           load_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                    load_wdata_i
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned PEND_W = $clog2(OUTSTANDING_MAX + 1);

  logic [PEND_W-1:0] pending;
  logic              rvalid_q;
  pipe_entry_t       new_entry;
  pipe_entry_t       exit_entry;
  logic [AW-1:0]     arr_idx;
  logic [31:0]       arr_rdata;
  logic              arr_re;

  // A returning response frees its slot in the same cycle, so a full counter still grants.
  assign instr_gnt_o = instr_req_i &&
                       ((pending < PEND_W'(NUM_OUTSTANDING)) || rvalid_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
    end else begin
      pending <= pending + PEND_W'(instr_gnt_o) - PEND_W'(rvalid_q);
    end
  end

  always_comb begin
    new_entry       = '0;
    new_entry.valid = instr_gnt_o;
    new_entry.idx   = word_index(instr_addr_i, BASE_ADDR);
`ifdef INSTR_MEM_ERR_CHECK_EN
    new_entry.err   = ({1'b0, instr_addr_i - BASE_ADDR} >= (33'(DEPTH_WORDS) << 2));
`endif
  end

  // The final stage is the grant itself when LATENCY is 1; the memory read register adds the last cycle.
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign exit_entry = new_entry;
    end else begin : g_pipe
      pipe_entry_t pipe_q [LATENCY-1];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q[0] <= new_entry;
          for (int i = 1; i < int'(LATENCY) - 1; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign exit_entry = pipe_q[LATENCY-2];
    end
  endgenerate

  assign arr_idx = exit_entry.idx[AW-1:0];

  logic unused_idx_hi;
  assign unused_idx_hi = ^exit_entry.idx[IDX_W-1:AW];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= exit_entry.valid;
    end
  end

  assign instr_rvalid_o = rvalid_q;

`ifdef INSTR_MEM_ERR_CHECK_EN
  logic err_q;

  // err_q holds with rdata so a held err response keeps reading back as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (exit_entry.valid) begin
      err_q <= exit_entry.err;
    end
  end

  assign arr_re        = exit_entry.valid && !exit_entry.err;
  assign instr_err_o   = rvalid_q && err_q;
  assign instr_rdata_o = err_q ? 32'h0 : arr_rdata;
`else
  logic unused_err;
  assign unused_err    = exit_entry.err;
  assign arr_re        = exit_entry.valid;
  assign instr_err_o   = 1'b0;
  assign instr_rdata_o = arr_rdata;
`endif

  instr_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .rstn  (rstn),
    .re    (arr_re),
    .raddr (arr_idx),
    .rdata (arr_rdata),
    .we    (load_we_i),
    .waddr (load_addr_i),
    .wdata (load_wdata_i)
  );

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: three configurations, directed scenarios plus a randomized scoreboard run.
module tb_instr_mem_responder;

  localparam int          DEPTH  = 64;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0100;
  localparam logic [31:0] BASE_C = 32'h0000_0000;
  localparam int          LAT_A  = 1;
  localparam int          N_A    = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        a_req = 0, a_gnt, a_rvalid, a_err, a_we = 0;
  logic [31:0] a_addr = 0, a_rdata, a_wdata = 0;
  logic [5:0]  a_waddr = 0;
  logic        b_req = 0, b_gnt, b_rvalid, b_err, b_we = 0;
  logic [31:0] b_addr = 0, b_rdata, b_wdata = 0;
  logic [5:0]  b_waddr = 0;
  logic        c_req = 0, c_gnt, c_rvalid, c_err, c_we = 0;
  logic [31:0] c_addr = 0, c_rdata, c_wdata = 0;
  logic [5:0]  c_waddr = 0;

  instr_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE_A), .LATENCY(1), .NUM_OUTSTANDING(2)) u_a (
    .clk(clk), .rstn(rstn), .instr_req_i(a_req), .instr_gnt_o(a_gnt), .instr_addr_i(a_addr),
    .instr_rdata_o(a_rdata), .instr_rvalid_o(a_rvalid), .instr_err_o(a_err),
    .load_we_i(a_we), .load_addr_i(a_waddr), .load_wdata_i(a_wdata));

  instr_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE_B), .LATENCY(3), .NUM_OUTSTANDING(1)) u_b (
    .clk(clk), .rstn(rstn), .instr_req_i(b_req), .instr_gnt_o(b_gnt), .instr_addr_i(b_addr),
    .instr_rdata_o(b_rdata), .instr_rvalid_o(b_rvalid), .instr_err_o(b_err),
    .load_we_i(b_we), .load_addr_i(b_waddr), .load_wdata_i(b_wdata));

  instr_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE_C), .LATENCY(4), .NUM_OUTSTANDING(4)) u_c (
    .clk(clk), .rstn(rstn), .instr_req_i(c_req), .instr_gnt_o(c_gnt), .instr_addr_i(c_addr),
    .instr_rdata_o(c_rdata), .instr_rvalid_o(c_rvalid), .instr_err_o(c_err),
    .load_we_i(c_we), .load_addr_i(c_waddr), .load_wdata_i(c_wdata));

  function automatic logic [31:0] prog(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for u_a: a queue of granted fetches, each read from the model memory
  // just before the load write of the edge on which it leaves the latency pipe.
  typedef struct {
    int          resp;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } txn_t;

  txn_t        q[$];
  logic [31:0] mem_a [DEPTH];
  bit          mon_en    = 0;
  bit          have_last = 0;
  logic [31:0] last_rdata = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    logic        ev;
    logic        eg;
    logic [31:0] off;
    cyc++;
    if (!rstn) begin
      q.delete();
      have_last = 0;
    end else if (mon_en) begin
      ev = (q.size() > 0) && (q[0].resp == cyc);
      eg = a_req && ((q.size() < N_A) || ev);
      checks++;
      if (a_gnt !== eg) begin
        failures++;
        $display("FAIL mon_gnt cyc=%0d got=%b exp=%b", cyc, a_gnt, eg);
      end
      checks++;
      if (a_rvalid !== ev) begin
        failures++;
        $display("FAIL mon_rvalid cyc=%0d got=%b exp=%b", cyc, a_rvalid, ev);
      end
      if (ev) begin
        checks++;
        if (a_rdata !== q[0].data || a_err !== q[0].err) begin
          failures++;
          $display("FAIL mon_resp cyc=%0d got=%h/%b exp=%h/%b", cyc, a_rdata, a_err, q[0].data, q[0].err);
        end
        last_rdata = q[0].data;
        have_last  = 1;
        q.delete(0);
      end else begin
        checks++;
        if (a_err !== 1'b0 || (have_last && a_rdata !== last_rdata)) begin
          failures++;
          $display("FAIL mon_idle cyc=%0d got=%h/%b exp=%h/0", cyc, a_rdata, a_err, last_rdata);
        end
      end
      if (a_req && a_gnt) q.push_back('{cyc + LAT_A, a_addr, 32'h0, 1'b0});
      foreach (q[i]) begin
        if (q[i].resp - 1 == cyc) begin
          off       = q[i].addr - BASE_A;
          q[i].err  = 1'b0;
          q[i].data = mem_a[off[7:2]];
`ifdef INSTR_MEM_ERR_CHECK_EN
          if (off >= 32'(4 * DEPTH)) begin
            q[i].err  = 1'b1;
            q[i].data = 32'h0;
          end
`endif
        end
      end
    end
    if (a_we) mem_a[a_waddr] = a_wdata;
  end

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    checks++;
    if ({a_rvalid, a_err, a_gnt, b_rvalid, b_err, b_gnt, c_rvalid, c_err, c_gnt} !== 9'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0", {a_rvalid, a_err, a_gnt, b_rvalid, b_err, b_gnt, c_rvalid, c_err, c_gnt});
    end
    checks++;
    if (a_rdata !== 32'h0 || b_rdata !== 32'h0 || c_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h/%h exp=0", a_rdata, b_rdata, c_rdata);
    end
    checks++;
    if (u_a.pending !== 3'd0) begin
      failures++;
      $display("FAIL reset_pending got=%0d exp=0", u_a.pending);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt, c_gnt, a_rvalid} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=0", {a_gnt, b_gnt, c_gnt, a_rvalid});
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      a_we = 1; b_we = 1; c_we = 1;
      a_waddr = 6'(i); b_waddr = 6'(i); c_waddr = 6'(i);
      a_wdata = prog(i); b_wdata = prog(i); c_wdata = prog(i);
    end
    tick();
    a_we = 0; b_we = 0; c_we = 0;
  endtask

  task automatic test_load_fetch();
    logic [31:0] words [4];
    words = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    for (int i = 0; i < 4; i++) begin
      tick();
      a_we = 1; a_waddr = 6'(i); a_wdata = words[i];
    end
    tick();
    a_we = 0; a_req = 1; a_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (a_gnt !== (i < 4)) begin
        failures++;
        $display("FAIL b2b_gnt i=%0d got=%b exp=%b", i, a_gnt, (i < 4));
      end
      checks++;
      if (a_rvalid !== (i > 0 && i < 5)) begin
        failures++;
        $display("FAIL b2b_rvalid i=%0d got=%b exp=%b", i, a_rvalid, (i > 0 && i < 5));
      end
      if (i > 0 && i < 5) begin
        checks++;
        if (a_rdata !== words[i-1] || a_err !== 1'b0) begin
          failures++;
          $display("FAIL b2b_rdata i=%0d got=%h exp=%h", i, a_rdata, words[i-1]);
        end
      end
      tick();
      if (i + 1 < 4) a_addr = 32'(4 * (i + 1));
      else a_req = 0;
    end
  endtask

  task automatic test_collision();
    a_req = 1; a_addr = 32'd20;
    a_we = 1; a_waddr = 6'd5; a_wdata = 32'hDEAD_BEEF;
    tick();
    a_req = 0; a_we = 0;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== prog(5)) begin
      failures++;
      $display("FAIL collision_old got=%b/%h exp=1/%h", a_rvalid, a_rdata, prog(5));
    end
    tick();
    a_req = 1; a_addr = 32'd20;
    tick();
    a_req = 0;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL collision_new got=%b/%h exp=1/deadbeef", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_unaligned();
    tick();
    a_req = 1; a_addr = 32'h0000_0006;
    tick();
    a_req = 0;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'h0010_0093 || a_err !== 1'b0) begin
      failures++;
      $display("FAIL unaligned got=%b/%h/%b exp=1/00100093/0", a_rvalid, a_rdata, a_err);
    end
  endtask

  task automatic test_range();
    logic [31:0] exp_d;
    logic        exp_e;
`ifdef INSTR_MEM_ERR_CHECK_EN
    exp_d = 32'h0;
    exp_e = 1'b1;
`else
    exp_d = 32'h0000_0013;
    exp_e = 1'b0;
`endif
    tick();
    a_req = 1; a_addr = BASE_A + 32'(4 * DEPTH);
    tick();
    a_req = 0;
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== exp_d || a_err !== exp_e) begin
      failures++;
      $display("FAIL range_resp got=%b/%h/%b exp=1/%h/%b", a_rvalid, a_rdata, a_err, exp_d, exp_e);
    end
    tick();
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0 || a_err !== 1'b0 || a_rdata !== exp_d) begin
      failures++;
      $display("FAIL range_hold got=%b/%h/%b exp=0/%h/0", a_rvalid, a_rdata, a_err, exp_d);
    end
  endtask

  task automatic test_limit();
    tick();
    b_req = 1; b_addr = BASE_B + 32'd28;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (b_gnt !== (k % 3 == 0)) begin
        failures++;
        $display("FAIL limit_gnt k=%0d got=%b exp=%b", k, b_gnt, (k % 3 == 0));
      end
      checks++;
      if (b_rvalid !== (k >= 3 && k % 3 == 0)) begin
        failures++;
        $display("FAIL limit_rvalid k=%0d got=%b exp=%b", k, b_rvalid, (k >= 3 && k % 3 == 0));
      end
      if (k >= 3 && k % 3 == 0) begin
        checks++;
        if (b_rdata !== prog(7)) begin
          failures++;
          $display("FAIL limit_rdata k=%0d got=%h exp=%h", k, b_rdata, prog(7));
        end
      end
      checks++;
      if (u_b.pending > 3'd1) begin
        failures++;
        $display("FAIL limit_pending k=%0d got=%0d exp<=1", k, u_b.pending);
      end
      tick();
    end
    b_req = 0;
  endtask

  task automatic test_throughput();
    tick();
    c_req = 1; c_addr = 32'h0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      checks++;
      if (c_gnt !== (k < 6)) begin
        failures++;
        $display("FAIL tput_gnt k=%0d got=%b exp=%b", k, c_gnt, (k < 6));
      end
      checks++;
      if (c_rvalid !== (k >= 4 && k < 10)) begin
        failures++;
        $display("FAIL tput_rvalid k=%0d got=%b exp=%b", k, c_rvalid, (k >= 4 && k < 10));
      end
      if (k >= 4 && k < 10) begin
        checks++;
        if (c_rdata !== prog(k - 4)) begin
          failures++;
          $display("FAIL tput_rdata k=%0d got=%h exp=%h", k, c_rdata, prog(k - 4));
        end
      end
      tick();
      if (k + 1 < 6) c_addr = 32'(4 * (k + 1));
      else c_req = 0;
    end
  endtask

  task automatic test_reset_midflight();
    c_req = 1; c_addr = 32'd40;
    tick();
    c_addr = 32'd44;
    tick();
    c_req = 0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (c_rvalid !== 1'b0 || c_rdata !== 32'h0 || c_err !== 1'b0 || u_c.pending !== 3'd0) begin
      failures++;
      $display("FAIL midflight_reset got=%b/%h/%b/%0d exp=0/0/0/0", c_rvalid, c_rdata, c_err, u_c.pending);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (c_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL midflight_ghost k=%0d got=%b exp=0", k, c_rvalid);
      end
    end
  endtask

  task automatic test_random();
    tick();
    a_req = 0; a_we = 0;
    tick();
    tick();
    mon_en = 1;
    for (int n = 0; n < 400; n++) begin
      a_req = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       a_addr = $urandom();
        1:       a_addr = BASE_A + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
        default: a_addr = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      endcase
      a_we    = ($urandom_range(0, 3) == 0);
      a_waddr = ($urandom_range(0, 3) == 0) ? a_addr[7:2] : 6'($urandom_range(0, 63));
      a_wdata = $urandom();
      tick();
    end
    a_req = 0; a_we = 0;
    tick();
    tick();
    mon_en = 0;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL random_drain got=%0d outstanding exp=0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_load_fetch();
    test_collision();
    test_unaligned();
    test_range();
    test_limit();
    test_throughput();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Instruction-side memory responder: the memory end of the req/gnt/rvalid instruction fetch interface driven by the fetch stage. It accepts word-aligned fetch requests, limits how many are in flight, and returns read data in order after a fixed, parameterised latency. A separate load port lets benches and boot logic write the program image. It is used as the instruction memory model in core-level simulation and as the on-chip instruction RAM wrapper.

## Interface
- DEPTH_WORDS, 1024, memory size in 32-bit words; power of two, ≥ 4
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH_WORDS-aligned
- LATENCY, 1, cycles from grant to rvalid; legal 1..4
- NUM_OUTSTANDING, 2, max granted-but-unreturned requests; legal 1..4
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  request accepted this cycle (combinational)
- instr_addr_i  in  32  byte address; bits [1:0] ignored
- instr_rdata_o  out  32  returned instruction word
- instr_rvalid_o  out  1  rdata/err valid, one cycle per granted request
- instr_err_o  out  1  access error for this response (see Configuration)
- load_we_i  in  1  program-load write strobe
- load_addr_i  in  $clog2(DEPTH_WORDS)  word index for load write
- load_wdata_i  in  32  load write data

## Operation
- Word index: idx = (instr_addr_i − BASE_ADDR) >> 2, truncated to $clog2(DEPTH_WORDS) bits.
- pending counter, 0..NUM_OUTSTANDING, tracks granted requests not yet returned.
- instr_gnt_o = instr_req_i && (pending < NUM_OUTSTANDING || instr_rvalid_o).
- A grant pushes {valid, idx, err} into a LATENCY-stage shift pipe. The pipe advances every cycle and never stalls.
- At pipe exit the memory is read, and instr_rdata_o, instr_rvalid_o and instr_err_o are registered.
- pending_next = pending + grant − instr_rvalid_o. Simultaneous grant and return leaves pending unchanged.
- Responses are strictly in request order. The requester has no backpressure on rvalid.
- When the final read and a load write hit the same word in the same cycle, the read returns the old contents (read-before-write).
- A load write to any other word has no effect on in-flight reads. Loads are accepted every cycle regardless of fetch traffic.
- When rvalid is low, rdata holds its last value. err is 0 whenever rvalid is 0.
- Memory contents are not reset.

## Timing
- Reset values: instr_rvalid_o 0, instr_rdata_o 0, instr_err_o 0, pending 0, all pipe valid bits 0.
- instr_gnt_o is 0 while instr_req_i is 0.
- Grant sampled at edge T gives instr_rvalid_o high during the cycle after edge T+LATENCY−1. For LATENCY=1, this is the cycle after the grant.
- Throughput: with NUM_OUTSTANDING ≥ LATENCY, one grant per cycle is sustained indefinitely.
- With NUM_OUTSTANDING < LATENCY, gnt deasserts once pending reaches the limit. It reasserts in the cycle the oldest rvalid is high.
- Reset asserted mid-operation drops all in-flight requests. No rvalid is produced for them after reset release.
- The requester may change or drop instr_req_i at any time. Only cycles with req && gnt generate responses.

## Configuration
- INSTR_MEM_ERR_CHECK_EN defined:
  - an address outside [BASE_ADDR, BASE_ADDR + 4·DEPTH_WORDS) sets err in its pipe entry;
  - its response has instr_err_o=1 and instr_rdata_o=0, with the same latency and ordering as a normal response.
- Not defined:
  - the index wraps modulo DEPTH_WORDS;
  - instr_err_o is tied 0 and the range comparator is absent.

## Structure
- Package instr_mem_pkg holds:
  - the pipe entry struct typedef (valid, idx, err);
  - the LATENCY and NUM_OUTSTANDING bounds constants;
  - a function computing idx from address and BASE_ADDR.
- One sub-module, instr_mem_array: DEPTH_WORDS×32 storage with one synchronous read port and one write port, read-before-write on collision.
- Counter, grant logic, latency pipe and range check live in the top.

## Test plan
- Reset, then load words 0..3 = 32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193. Request byte addresses 0,4,8,12 back-to-back (LATENCY=1, NUM_OUTSTANDING=2) → four grants in consecutive cycles, rvalid one cycle after each, rdata in order.
- LATENCY=3, NUM_OUTSTANDING=1, req held high → gnt high once every 3 cycles, in the cycle its predecessor's rvalid is high. pending never exceeds 1.
- In the exit cycle of a read to word 5, load_we_i writes word 5 with 32'hDEAD_BEEF → that response returns the old value. The next read of word 5 returns 32'hDEAD_BEEF.
- With INSTR_MEM_ERR_CHECK_EN, request address BASE_ADDR + 4·DEPTH_WORDS → rvalid=1, err=1, rdata=0. Without the macro, the same request returns word 0 with err=0.
- Assert rstn low with 2 requests in flight → rvalid, rdata, err and pending are 0 immediately. No response appears after release.
- Request address 32'h0000_0006 → data of word 1 (bits [1:0] ignored).
